// File: rtl/receptor_serial_pkg.sv
// -----------------------------------------------------------------------------
// receptor_pkg
//   Shared definitions for the serial receiver slice:
//   - state_t   : receiver FSM state encoding
//   - START_BIT : line level that opens a frame
//   - STOP_BIT  : line level that closes a good frame
// -----------------------------------------------------------------------------
package receptor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage : receptor_pkg

// File: rtl/buffer_salida.sv
// -----------------------------------------------------------------------------
// buffer_salida
//   One-entry output holding register with a valid/ready handshake.
//   A write is accepted when the slot is empty or is being consumed in the
//   same cycle; otherwise the write is dropped and OVERRUN-style pulse fires.
//
// Ports
//   clk      in   1       rising-edge clock
//   RESET    in   1       synchronous, active-high reset
//   wr_en    in   1       good frame ready to be stored this cycle
//   wr_data  in   DATA_W  word to store
//   wr_par   in   1       parity-error flag travelling with the word
//   rdy      in   1       consumer accepts the word when vld && rdy
//   data     out  DATA_W  last accepted word (held after consumption)
//   vld      out  1       data holds an unconsumed word
//   err_par  out  1       parity flag of the stored word, gated by vld
//   overrun  out  1       one-cycle pulse: write dropped, slot was full
// -----------------------------------------------------------------------------
module buffer_salida #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_par,
  input  logic              rdy,
  output logic [DATA_W-1:0] data,
  output logic              vld,
  output logic              err_par,
  output logic              overrun
);

  logic par_q;
  logic consume;
  logic accept;

  assign consume = vld && rdy;
  // A simultaneous consume frees the slot in time for the incoming word.
  assign accept  = wr_en && (!vld || consume);

  always_ff @(posedge clk) begin
    if (RESET) begin
      // NOTE: the data register is reset even though it is plain storage,
      // because DATA_OUT must read 0 straight out of reset.
      data    <= '0;
      vld     <= 1'b0;
      par_q   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (accept) begin
        data  <= wr_data;
        par_q <= wr_par;
        vld   <= 1'b1;
      end else if (wr_en) begin
        overrun <= 1'b1;
      end else if (consume) begin
        vld <= 1'b0;
      end
    end
  end

  // The flag only has meaning while a word is pending.
  assign err_par = par_q && vld;

endmodule : buffer_salida

// File: rtl/receptor_serial.sv
// -----------------------------------------------------------------------------
// receptor_serial
//   Rebuilds framed words from the serial stream of the upstream shift
//   register. Frame, LSB first: start(0), DATA_W data bits, optional parity
//   bit, stop(1). Good frames go out through a one-entry valid/ready buffer.
//
// Ports
//   clk       in   1       rising-edge clock
//   RESET     in   1       synchronous, active-high reset
//   S_IN      in   1       serial bit (upstream S_OUT)
//   BIT_VLD   in   1       S_IN carries a bit this cycle (upstream ENB)
//   DATA_OUT  out  DATA_W  last accepted word
//   DATA_VLD  out  1       DATA_OUT holds an unconsumed word
//   DATA_RDY  in   1       consumer takes the word when DATA_VLD && DATA_RDY
//   ERR_PAR   out  1       parity mismatch on the word in DATA_OUT
//   ERR_STOP  out  1       one-cycle pulse: bad stop bit, frame dropped
//   OVERRUN   out  1       one-cycle pulse: good frame dropped, buffer full
//   BUSY      out  1       receiver FSM is inside a frame
// -----------------------------------------------------------------------------
module receptor_serial
  import receptor_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              S_IN,
  input  logic              BIT_VLD,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              DATA_VLD,
  input  logic              DATA_RDY,
  output logic              ERR_PAR,
  output logic              ERR_STOP,
  output logic              OVERRUN,
  output logic              BUSY
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic ODD = (PARITY_ODD != 0);
  localparam logic HAS_PAR = (PARITY_EN != 0);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              par_err, par_err_nxt;
  logic              err_stop_q, err_stop_nxt;
  logic              wr_en;
  logic              last_bit;

  assign last_bit = (cnt == CNT_W'(DATA_W - 1));

  // Next-state, datapath and write-request logic. Everything only advances
  // on cycles that carry a bit; BIT_VLD=0 freezes the frame in place.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_nxt    = state;
    cnt_nxt      = cnt;
    shreg_nxt    = shreg;
    par_err_nxt  = par_err;
    err_stop_nxt = 1'b0;
    wr_en        = 1'b0;

    if (BIT_VLD) begin
      unique case (state)
        IDLE: begin
          if (S_IN == START_BIT) begin
            state_nxt   = DATA;
            cnt_nxt     = '0;
            par_err_nxt = 1'b0;
          end
        end

        DATA: begin
          // LSB first: each new bit enters at the top and walks down, so
          // the first data bit ends up in bit 0.
          shreg_nxt           = shreg >> 1;
          shreg_nxt[DATA_W-1] = S_IN;
          cnt_nxt             = cnt + CNT_W'(1);
          if (last_bit) begin
            state_nxt = HAS_PAR ? PAR : STOP;
          end
        end

        PAR: begin
          par_err_nxt = (S_IN != ((^shreg) ^ ODD));
          state_nxt   = STOP;
        end

        STOP: begin
          if (S_IN == STOP_BIT) begin
            wr_en = 1'b1;
          end else begin
            err_stop_nxt = 1'b1;
          end
          state_nxt = IDLE;
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      par_err    <= 1'b0;
      err_stop_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shreg      <= shreg_nxt;
      par_err    <= par_err_nxt;
      err_stop_q <= err_stop_nxt;
    end
  end

  // The write request is combinational on the stop-bit cycle, so the word
  // lands in the buffer on the stop sampling edge itself.
  buffer_salida #(
    .DATA_W (DATA_W)
  ) u_buffer (
    .clk     (clk),
    .RESET   (RESET),
    .wr_en   (wr_en),
    .wr_data (shreg),
    .wr_par  (par_err),
    .rdy     (DATA_RDY),
    .data    (DATA_OUT),
    .vld     (DATA_VLD),
    .err_par (ERR_PAR),
    .overrun (OVERRUN)
  );

  assign ERR_STOP = err_stop_q;
  assign BUSY     = (state != IDLE);

endmodule : receptor_serial

// File: tb/tb_receptor_serial.sv
// -----------------------------------------------------------------------------
// tb_receptor_serial
//   Self-checking bench for receptor_serial (DATA_W=4, even parity).
//   Table of hand-derived frames, hand sequences for overrun, gapped input
//   and mid-frame reset, then random frames against a word-level model.
// -----------------------------------------------------------------------------
module tb_receptor_serial;

  logic       clk = 1'b0;
  logic       RESET;
  logic       S_IN;
  logic       BIT_VLD;
  logic [3:0] DATA_OUT;
  logic       DATA_VLD;
  logic       DATA_RDY;
  logic       ERR_PAR;
  logic       ERR_STOP;
  logic       OVERRUN;
  logic       BUSY;

  int checks   = 0;
  int failures = 0;

  receptor_serial #(
    .DATA_W     (4),
    .PARITY_EN  (1),
    .PARITY_ODD (0)
  ) dut (
    .clk      (clk),
    .RESET    (RESET),
    .S_IN     (S_IN),
    .BIT_VLD  (BIT_VLD),
    .DATA_OUT (DATA_OUT),
    .DATA_VLD (DATA_VLD),
    .DATA_RDY (DATA_RDY),
    .ERR_PAR  (ERR_PAR),
    .ERR_STOP (ERR_STOP),
    .OVERRUN  (OVERRUN),
    .BUSY     (BUSY)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic       par_bit;
    logic       stop_bit;
    logic [3:0] exp_out;
    logic       exp_vld;
    logic       exp_par;
    logic       exp_stop;
  } vec_t;

  vec_t vecs [7];

  // Word-level reference of the output slot used in the random phase.
  logic       m_vld;
  logic [3:0] m_data;
  logic       m_par;
  logic       busy_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame with explicit parity and stop levels. 'gap' idle cycles
  // (BIT_VLD=0) follow every bit except the stop bit.
  task automatic send_frame(input logic [3:0] w, input logic pb, input logic sb,
                            input int gap, input logic rdy_base, input logic rdy_stop);
    logic [6:0] bits;
    bits = {sb, pb, w, 1'b0};
    for (int i = 0; i < 7; i++) begin
      S_IN     = bits[i];
      BIT_VLD  = 1'b1;
      DATA_RDY = (i == 6) ? rdy_stop : rdy_base;
      tick();
      BIT_VLD  = 1'b0;
      DATA_RDY = rdy_base;
      if (i < 6) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          if (BUSY !== 1'b1) busy_drop = 1'b1;
        end
      end
    end
    S_IN = 1'b1;
  endtask

  // One cycle of the random phase: drive, advance, update the model, compare.
  // ev: 0 no frame end, 1 good stop bit, 2 bad stop bit.
  task automatic do_tick(input logic s, input logic bv, input logic rdy, input int ev,
                         input logic [3:0] w, input logic pe, input logic exp_busy);
    logic consume;
    logic m_ovr;
    S_IN     = s;
    BIT_VLD  = bv;
    DATA_RDY = rdy;
    tick();
    consume = m_vld && rdy;
    m_ovr   = 1'b0;
    if (ev == 1) begin
      if (!m_vld || consume) begin
        m_vld  = 1'b1;
        m_data = w;
        m_par  = pe;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (consume) begin
      m_vld = 1'b0;
    end
    check("rnd_vld", DATA_VLD, m_vld);
    check("rnd_data", DATA_OUT, m_data);
    if (m_vld) check("rnd_par", ERR_PAR, m_par);
    check("rnd_ovr", OVERRUN, m_ovr);
    check("rnd_stop", ERR_STOP, (ev == 2));
    check("rnd_busy", BUSY, exp_busy);
  endtask

  task automatic rand_frame();
    logic [3:0] w;
    logic       bad_par;
    logic       bad_stop;
    logic [6:0] bits;
    int         gap;
    int         idle;
    w        = 4'($urandom);
    bad_par  = ($urandom_range(0, 5) == 0);
    bad_stop = ($urandom_range(0, 7) == 0);
    bits     = {~bad_stop, (^w) ^ bad_par, w, 1'b0};
    for (int i = 0; i < 7; i++) begin
      do_tick(bits[i], 1'b1, 1'($urandom_range(0, 1)),
              (i == 6) ? (bad_stop ? 2 : 1) : 0, w, bad_par, (i != 6));
      if (i < 6) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++)
          do_tick(1'($urandom), 1'b0, 1'($urandom_range(0, 1)), 0, w, bad_par, 1'b1);
      end
    end
    idle = $urandom_range(0, 2);
    for (int k = 0; k < idle; k++)
      do_tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, w, bad_par, 1'b0);
  endtask

  initial begin
    //         data   par   stop  out    vld   par   stop
    vecs[0] = '{4'hA, 1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{4'h3, 1'b1, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{4'h5, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{4'hF, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{4'h0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{4'h1, 1'b1, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{4'h7, 1'b0, 1'b1, 4'h7, 1'b1, 1'b1, 1'b0};

    RESET     = 1'b1;
    S_IN      = 1'b1;
    BIT_VLD   = 1'b0;
    DATA_RDY  = 1'b0;
    busy_drop = 1'b0;
    tick();
    tick();
    check("rst_data", DATA_OUT, 4'h0);
    check("rst_vld", DATA_VLD, 1'b0);
    check("rst_par", ERR_PAR, 1'b0);
    check("rst_stop", ERR_STOP, 1'b0);
    check("rst_ovr", OVERRUN, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    RESET = 1'b0;
    tick();

    // Good frame with a consumer that is always ready.
    send_frame(4'hA, 1'b0, 1'b1, 0, 1'b1, 1'b1);
    check("t1_vld", DATA_VLD, 1'b1);
    check("t1_data", DATA_OUT, 4'hA);
    check("t1_par", ERR_PAR, 1'b0);
    check("t1_busy", BUSY, 1'b0);
    tick();
    check("t1_vld_drop", DATA_VLD, 1'b0);
    check("t1_data_held", DATA_OUT, 4'hA);
    DATA_RDY = 1'b0;

    // Table of frames: check after stop, after a hold cycle, after consume.
    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].data, vecs[v].par_bit, vecs[v].stop_bit, 0, 1'b0, 1'b0);
      check("vec_stop", ERR_STOP, vecs[v].exp_stop);
      check("vec_vld", DATA_VLD, vecs[v].exp_vld);
      check("vec_data", DATA_OUT, vecs[v].exp_out);
      check("vec_par", ERR_PAR, vecs[v].exp_par);
      check("vec_ovr", OVERRUN, 1'b0);
      check("vec_busy", BUSY, 1'b0);
      tick();
      check("vec_stop_pulse", ERR_STOP, 1'b0);
      check("vec_hold_vld", DATA_VLD, vecs[v].exp_vld);
      check("vec_hold_par", ERR_PAR, vecs[v].exp_par);
      DATA_RDY = 1'b1;
      tick();
      DATA_RDY = 1'b0;
      check("vec_consumed", DATA_VLD, 1'b0);
      check("vec_par_clr", ERR_PAR, 1'b0);
    end

    // Overrun: second good frame while the slot is still full.
    send_frame(4'h5, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    send_frame(4'hC, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    check("t4_ovr", OVERRUN, 1'b1);
    check("t4_data", DATA_OUT, 4'h5);
    check("t4_vld", DATA_VLD, 1'b1);
    check("t4_nostop", ERR_STOP, 1'b0);
    tick();
    check("t4_ovr_pulse", OVERRUN, 1'b0);
    DATA_RDY = 1'b1;
    tick();
    DATA_RDY = 1'b0;
    // Same pair, but the consumer takes the old word on the stop cycle.
    send_frame(4'h5, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    send_frame(4'hC, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    check("t4b_ovr", OVERRUN, 1'b0);
    check("t4b_data", DATA_OUT, 4'hC);
    check("t4b_vld", DATA_VLD, 1'b1);
    DATA_RDY = 1'b1;
    tick();
    DATA_RDY = 1'b0;

    // Gapped input: two idle cycles between bits.
    busy_drop = 1'b0;
    send_frame(4'h9, 1'b0, 1'b1, 2, 1'b0, 1'b0);
    check("t5_busy", busy_drop, 1'b0);
    check("t5_data", DATA_OUT, 4'h9);
    check("t5_vld", DATA_VLD, 1'b1);
    check("t5_par", ERR_PAR, 1'b0);
    check("t5_stop", ERR_STOP, 1'b0);

    // Reset after start + 2 data bits while a word is still pending.
    BIT_VLD = 1'b1;
    S_IN = 1'b0; tick();
    S_IN = 1'b1; tick();
    S_IN = 1'b0; tick();
    BIT_VLD = 1'b0;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("t6_data", DATA_OUT, 4'h0);
    check("t6_vld", DATA_VLD, 1'b0);
    check("t6_par", ERR_PAR, 1'b0);
    check("t6_stop", ERR_STOP, 1'b0);
    check("t6_ovr", OVERRUN, 1'b0);
    check("t6_busy", BUSY, 1'b0);
    send_frame(4'h6, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    check("t6_new_data", DATA_OUT, 4'h6);
    check("t6_new_vld", DATA_VLD, 1'b1);
    check("t6_new_par", ERR_PAR, 1'b0);

    // Random frames with random gaps, errors and consumer stalls.
    RESET = 1'b1;
    tick();
    RESET  = 1'b0;
    m_vld  = 1'b0;
    m_data = 4'h0;
    m_par  = 1'b0;
    for (int f = 0; f < 150; f++) rand_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_receptor_serial
